// File: rtl/tpu_conv_sequencer.sv
// Walks every output position of a valid-mode 2-D convolution in raster order,
// NUM_UNITS positions per group, handshaking the TPU datapath and streaming results.
module tpu_conv_sequencer #(
  parameter  int DATA_WIDTH   = 16,
  parameter  int IMAGE_WIDTH  = 5,
  parameter  int IMAGE_HEIGHT = 5,
  parameter  int NUM_UNITS    = 2,
  localparam int AW = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
  localparam int KW = $clog2(IMAGE_WIDTH),
  localparam int LW = (KW-1)*(KW-1)+1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [KW-1:0]                    cmd_kernel_dim,
  input  logic [AW-1:0]                    cmd_kernel_base,
  input  logic [AW-1:0]                    cmd_bias_addr,
  output logic                             cmd_error,
  output logic                             busy,
  output logic                             tpu_en,
  output logic                             tpu_read_mem1,
  output logic                             tpu_read_mem2,
  output logic                             tpu_simple_read,
  output logic [NUM_UNITS*AW-1:0]          tpu_start_addr_1,
  output logic [NUM_UNITS*AW-1:0]          tpu_start_addr_2,
  output logic [NUM_UNITS*AW-1:0]          tpu_simple_addr,
  output logic [KW-1:0]                    tpu_kernel_dim,
  output logic                             tpu_start,
  output logic [NUM_UNITS-1:0]             tpu_active_units,
  output logic [LW-1:0]                    tpu_length,
  input  logic                             tpu_mem_en1,
  input  logic                             tpu_mem_en2,
  input  logic                             tpu_done,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]  tpu_relu_out,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [NUM_UNITS*DATA_WIDTH-1:0]  res_data,
  output logic [NUM_UNITS-1:0]             res_mask,
  output logic [AW-1:0]                    res_index,
  output logic                             res_last
);

  // Counter width leaves headroom for pos + NUM_UNITS past the last position.
  localparam int CW   = AW + $clog2(NUM_UNITS) + 1;
  localparam int KMAX = (IMAGE_WIDTH < IMAGE_HEIGHT) ? IMAGE_WIDTH : IMAGE_HEIGHT;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_MEM, S_START, S_WAIT_DONE, S_OUTPUT
  } state_t;

  state_t                            state_q;
  logic [KW-1:0]                     k_q;
  logic [AW-1:0]                     kbase_q, bias_q;
  logic [CW-1:0]                     ow_q, p_q, pos_q, row_q, col_q;
  logic                              men1_q, men2_q;
  logic                              cmd_ready_q, cmd_error_q, busy_q;
  logic                              tpu_en_q, tpu_read_q, tpu_start_q;
  logic [LW-1:0]                     tpu_length_q;
  logic                              res_valid_q, res_last_q;
  logic [NUM_UNITS*DATA_WIDTH-1:0]   res_data_q;
  logic [NUM_UNITS-1:0]              res_mask_q;
  logic [AW-1:0]                     res_index_q;

  logic                              grp_active;
  logic                              cmd_bad;
  logic [CW-1:0]                     cmd_ow, cmd_oh;
  logic [NUM_UNITS-1:0]              lane_act;
  logic [NUM_UNITS*AW-1:0]           addr1_d, addr2_d, saddr_d;
  logic [CW-1:0]                     next_row, next_col;

  assign grp_active = (state_q == S_ISSUE) || (state_q == S_WAIT_MEM) ||
                      (state_q == S_START) || (state_q == S_WAIT_DONE);
  assign cmd_bad    = (cmd_kernel_dim == '0) || (int'(cmd_kernel_dim) > KMAX);
  assign cmd_ow     = CW'(IMAGE_WIDTH + 1)  - CW'(cmd_kernel_dim);
  assign cmd_oh     = CW'(IMAGE_HEIGHT + 1) - CW'(cmd_kernel_dim);

  // Step (row, col) lane by lane; the value after the last lane is the next group's origin.
  always_comb begin : lane_map
    logic [CW-1:0] r, c, lp;
    r        = row_q;
    c        = col_q;
    lp       = '0;
    lane_act = '0;
    addr1_d  = '0;
    addr2_d  = '0;
    saddr_d  = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      lp = pos_q + CW'(u);
      if (grp_active && (lp < p_q)) begin
        lane_act[u]          = 1'b1;
        addr1_d[u*AW +: AW]  = AW'(r * CW'(IMAGE_WIDTH) + c);
        addr2_d[u*AW +: AW]  = kbase_q;
        saddr_d[u*AW +: AW]  = bias_q;
      end
      if (c + CW'(1) == ow_q) begin
        c = '0;
        r = r + CW'(1);
      end else begin
        c = c + CW'(1);
      end
    end
    next_row = r;
    next_col = c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      kbase_q      <= '0;
      bias_q       <= '0;
      ow_q         <= '0;
      p_q          <= '0;
      pos_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      men1_q       <= 1'b0;
      men2_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      cmd_error_q  <= 1'b0;
      busy_q       <= 1'b0;
      tpu_en_q     <= 1'b0;
      tpu_read_q   <= 1'b0;
      tpu_start_q  <= 1'b0;
      tpu_length_q <= '0;
      res_valid_q  <= 1'b0;
      res_last_q   <= 1'b0;
      res_data_q   <= '0;
      res_mask_q   <= '0;
      res_index_q  <= '0;
    end else begin
      cmd_error_q <= 1'b0;
      tpu_read_q  <= 1'b0;
      tpu_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              cmd_error_q <= 1'b1;
            end else begin
              k_q          <= cmd_kernel_dim;
              kbase_q      <= cmd_kernel_base;
              bias_q       <= cmd_bias_addr;
              ow_q         <= cmd_ow;
              p_q          <= cmd_ow * cmd_oh;
              pos_q        <= '0;
              row_q        <= '0;
              col_q        <= '0;
              tpu_length_q <= LW'(cmd_kernel_dim) * LW'(cmd_kernel_dim);
              cmd_ready_q  <= 1'b0;
              busy_q       <= 1'b1;
              tpu_en_q     <= 1'b1;
              tpu_read_q   <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state_q <= S_WAIT_MEM;
        S_WAIT_MEM: begin
          // The two memories may report in different cycles; remember each one.
          men1_q <= men1_q | tpu_mem_en1;
          men2_q <= men2_q | tpu_mem_en2;
          if ((men1_q || tpu_mem_en1) && (men2_q || tpu_mem_en2)) begin
            men1_q      <= 1'b0;
            men2_q      <= 1'b0;
            tpu_en_q    <= 1'b0;
            tpu_start_q <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: state_q <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (tpu_done) begin
            res_data_q  <= tpu_relu_out;
            res_mask_q  <= lane_act;
            res_index_q <= pos_q[AW-1:0];
            res_last_q  <= (pos_q + CW'(NUM_UNITS)) >= p_q;
            res_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (res_last_q) begin
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              pos_q      <= pos_q + CW'(NUM_UNITS);
              row_q      <= next_row;
              col_q      <= next_col;
              tpu_en_q   <= 1'b1;
              tpu_read_q <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign cmd_error        = cmd_error_q;
  assign busy             = busy_q;
  assign tpu_en           = tpu_en_q;
  assign tpu_read_mem1    = tpu_read_q;
  assign tpu_read_mem2    = tpu_read_q;
  assign tpu_simple_read  = tpu_read_q;
  assign tpu_start_addr_1 = addr1_d;
  assign tpu_start_addr_2 = addr2_d;
  assign tpu_simple_addr  = saddr_d;
  assign tpu_kernel_dim   = k_q;
  assign tpu_start        = tpu_start_q;
  assign tpu_active_units = lane_act;
  assign tpu_length       = tpu_length_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;
  assign res_mask         = res_mask_q;
  assign res_index        = res_index_q;
  assign res_last         = res_last_q;

endmodule

// File: tb/tb_tpu_conv_sequencer.sv
// Randomized bench for tpu_conv_sequencer: a TPU responder checks each issued group
// against a position model and queues expected results for an independent result monitor.
module tb_tpu_conv_sequencer;

  localparam int DW = 16;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int NU = 2;
  localparam int AW = $clog2(W*H);
  localparam int KW = $clog2(W);
  localparam int LW = (KW-1)*(KW-1)+1;

  typedef struct {
    logic [NU*AW-1:0] a1, a2, sa;
    logic [NU-1:0]    mask;
    logic [AW-1:0]    idx;
    logic             last;
    logic [LW-1:0]    len;
    logic [KW-1:0]    k;
    logic [NU*DW-1:0] data;
  } grp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic [KW-1:0] cmd_kernel_dim = '0;
  logic [AW-1:0] cmd_kernel_base = '0;
  logic [AW-1:0] cmd_bias_addr = '0;
  logic tpu_mem_en1 = 1'b0, tpu_mem_en2 = 1'b0, tpu_done = 1'b0;
  logic [NU*DW-1:0] tpu_relu_out = '0;
  logic res_ready = 1'b0;

  logic cmd_ready, cmd_error, busy, tpu_en, tpu_read_mem1, tpu_read_mem2, tpu_simple_read;
  logic [NU*AW-1:0] tpu_start_addr_1, tpu_start_addr_2, tpu_simple_addr;
  logic [KW-1:0] tpu_kernel_dim;
  logic tpu_start;
  logic [NU-1:0] tpu_active_units;
  logic [LW-1:0] tpu_length;
  logic res_valid, res_last;
  logic [NU*DW-1:0] res_data;
  logic [NU-1:0] res_mask;
  logic [AW-1:0] res_index;

  tpu_conv_sequencer #(.DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .NUM_UNITS(NU)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kernel_dim(cmd_kernel_dim),
    .cmd_kernel_base(cmd_kernel_base), .cmd_bias_addr(cmd_bias_addr), .cmd_error(cmd_error),
    .busy(busy), .tpu_en(tpu_en), .tpu_read_mem1(tpu_read_mem1), .tpu_read_mem2(tpu_read_mem2),
    .tpu_simple_read(tpu_simple_read), .tpu_start_addr_1(tpu_start_addr_1),
    .tpu_start_addr_2(tpu_start_addr_2), .tpu_simple_addr(tpu_simple_addr),
    .tpu_kernel_dim(tpu_kernel_dim), .tpu_start(tpu_start), .tpu_active_units(tpu_active_units),
    .tpu_length(tpu_length), .tpu_mem_en1(tpu_mem_en1), .tpu_mem_en2(tpu_mem_en2),
    .tpu_done(tpu_done), .tpu_relu_out(tpu_relu_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_mask(res_mask), .res_index(res_index),
    .res_last(res_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  grp_t iss_q[$];
  grp_t res_q[$];

  int force_m1 = 0, force_m2 = 0, force_d = 0, force_stall = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference positions: raster index p maps to (p / OW, p % OW) in the image.
  task automatic push_groups(input int k, input int kb, input int bi);
    int ow, oh, np;
    grp_t g;
    ow = W - k + 1;
    oh = H - k + 1;
    np = ow * oh;
    for (int pos = 0; pos < np; pos += NU) begin
      g = '{default: '0};
      for (int u = 0; u < NU; u++) begin
        if (pos + u < np) begin
          g.a1[u*AW +: AW] = AW'(((pos + u) / ow) * W + (pos + u) % ow);
          g.a2[u*AW +: AW] = AW'(kb);
          g.sa[u*AW +: AW] = AW'(bi);
          g.mask[u] = 1'b1;
        end
      end
      g.idx  = AW'(pos);
      g.last = (pos + NU >= np);
      g.len  = LW'(k * k);
      g.k    = KW'(k);
      iss_q.push_back(g);
    end
  endtask

  // TPU responder: checks ISSUE contents, plays memory/done latency, records captured data.
  int   rsp_phase = 0;
  int   rsp_cnt = 0, rsp_m1 = 0, rsp_m2 = 0, rsp_dd = 0;
  grp_t cur;

  always @(negedge clk) begin
    if (reset) begin
      rsp_phase   = 0;
      tpu_mem_en1 = 1'b0;
      tpu_mem_en2 = 1'b0;
      tpu_done    = 1'b0;
      iss_q.delete();
      res_q.delete();
    end else begin
      for (int u = 0; u < NU; u++) tpu_relu_out[u*DW +: DW] = DW'($urandom);
      tpu_mem_en1 = 1'b0;
      tpu_mem_en2 = 1'b0;
      tpu_done    = 1'b0;
      case (rsp_phase)
        0: begin
          if (tpu_read_mem1) begin
            if (iss_q.size() == 0) begin
              chk("issue_unexpected", 128'(1), 128'(0));
            end else begin
              cur = iss_q.pop_front();
              chk("issue_strobes", 128'({tpu_en, tpu_read_mem2, tpu_simple_read, tpu_start}), 128'(4'b1110));
              chk("issue_addr1", 128'(tpu_start_addr_1), 128'(cur.a1));
              chk("issue_addr2", 128'(tpu_start_addr_2), 128'(cur.a2));
              chk("issue_simple", 128'(tpu_simple_addr), 128'(cur.sa));
              chk("issue_mask", 128'(tpu_active_units), 128'(cur.mask));
              chk("issue_len_k", 128'({tpu_length, tpu_kernel_dim}), 128'({cur.len, cur.k}));
              rsp_m1 = (force_m1 > 0) ? force_m1 : int'($urandom_range(1, 4));
              rsp_m2 = (force_m2 > 0) ? force_m2 : int'($urandom_range(1, 4));
              rsp_cnt = 0;
              rsp_phase = 1;
            end
          end else begin
            chk("idle_strobes", 128'({tpu_en, tpu_read_mem2, tpu_simple_read, tpu_start}), 128'(0));
            tpu_done = ($urandom_range(0, 7) == 0);
          end
        end
        1: begin
          rsp_cnt++;
          if (tpu_start) begin
            chk("start_cycle", 128'(rsp_cnt), 128'(((rsp_m1 > rsp_m2) ? rsp_m1 : rsp_m2) + 1));
            chk("start_mask_len", 128'({tpu_active_units, tpu_length}), 128'({cur.mask, cur.len}));
            rsp_cnt = 0;
            rsp_dd = (force_d > 0) ? force_d : int'($urandom_range(1, 4));
            rsp_phase = 2;
          end else if (rsp_cnt > 40) begin
            chk("start_timeout", 128'(1), 128'(0));
            rsp_phase = 0;
          end else begin
            chk("wait_mem_en", 128'(tpu_en), 128'(1));
            tpu_mem_en1 = (rsp_cnt == rsp_m1);
            tpu_mem_en2 = (rsp_cnt == rsp_m2);
            tpu_done    = ($urandom_range(0, 3) == 0);
          end
        end
        default: begin
          rsp_cnt++;
          if (tpu_start) chk("start_repeat", 128'(1), 128'(0));
          if (rsp_cnt == rsp_dd) begin
            tpu_done = 1'b1;
            cur.data = tpu_relu_out;
            res_q.push_back(cur);
            rsp_phase = 0;
          end
        end
      endcase
    end
  end

  // Result monitor: chooses res_ready, checks stability while stalled, pops on handshake.
  int            stall_left = 0;
  logic          have_prev = 1'b0;
  logic          chk_idle = 1'b0;
  logic [127:0]  prev_res = '0;
  grp_t          e;

  always @(negedge clk) begin
    if (reset) begin
      res_ready  = 1'b0;
      stall_left = 0;
      have_prev  = 1'b0;
      chk_idle   = 1'b0;
    end else begin
      if (chk_idle) begin
        chk("idle_after_last", 128'({busy, cmd_ready}), 128'(2'b01));
        chk_idle = 1'b0;
      end
      if (res_valid) begin
        if (!have_prev) begin
          stall_left = (force_stall > 0) ? force_stall : int'($urandom_range(0, 2));
          prev_res   = 128'({res_data, res_mask, res_index, res_last, 1'b0});
          have_prev  = 1'b1;
        end else begin
          chk("res_stable", 128'({res_data, res_mask, res_index, res_last, tpu_read_mem1}), prev_res);
        end
        if (stall_left == 0) begin
          res_ready = 1'b1;
          have_prev = 1'b0;
          if (res_q.size() == 0) begin
            chk("res_unexpected", 128'(1), 128'(0));
          end else begin
            e = res_q.pop_front();
            chk("res_data", 128'(res_data), 128'(e.data));
            chk("res_mask", 128'(res_mask), 128'(e.mask));
            chk("res_index", 128'(res_index), 128'(e.idx));
            chk("res_last", 128'(res_last), 128'(e.last));
            $display("result idx=%0d mask=%b last=%0d data=%h", res_index, res_mask, res_last, res_data);
            chk_idle = e.last;
          end
        end else begin
          res_ready = 1'b0;
          stall_left--;
        end
      end else begin
        have_prev = 1'b0;
        res_ready = ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_ctrl", 128'({cmd_error, busy, tpu_en, tpu_read_mem1, tpu_read_mem2, tpu_simple_read,
                          tpu_start, tpu_kernel_dim, tpu_active_units, tpu_length}), 128'(0));
    chk("rst_addr", 128'({tpu_start_addr_1, tpu_start_addr_2, tpu_simple_addr}), 128'(0));
    chk("rst_res", 128'({res_valid, res_data, res_mask, res_index, res_last}), 128'(0));
  endtask

  task automatic send_cmd(input int k, input int kb, input int bi);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("cmd_ready_wait", 128'(cmd_ready), 128'(1));
    push_groups(k, kb, bi);
    cmd_kernel_dim  = KW'(k);
    cmd_kernel_base = AW'(kb);
    cmd_bias_addr   = AW'(bi);
    cmd_valid       = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_accept", 128'({busy, cmd_ready, cmd_error}), 128'(3'b100));
  endtask

  task automatic run_cmd(input int k, input int kb, input int bi);
    send_cmd(k, kb, bi);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("busy_drop", 128'(busy), 128'(0));
    chk("groups_left", 128'(iss_q.size() + res_q.size()), 128'(0));
  endtask

  task automatic bad_cmd(input int k);
    @(negedge clk);
    cmd_kernel_dim = KW'(k);
    cmd_valid      = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_error_pulse", 128'({cmd_error, busy, cmd_ready}), 128'(3'b101));
    @(negedge clk);
    chk("cmd_error_clear", 128'({cmd_error, busy, cmd_ready}), 128'(3'b001));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    run_cmd(3, 7, 3);
    run_cmd(5, 2, 9);
    bad_cmd(0);
    bad_cmd(6);
    bad_cmd(7);

    force_m1 = 2;
    force_m2 = 5;
    run_cmd(5, 0, 1);
    force_m1 = 0;
    force_m2 = 0;

    force_stall = 4;
    run_cmd(3, 4, 4);
    force_stall = 0;

    for (int i = 0; i < 6; i++)
      run_cmd(int'($urandom_range(1, 5)), int'($urandom_range(0, 24)), int'($urandom_range(0, 24)));

    force_d = 20;
    send_cmd(3, 5, 6);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_phase == 2) break;
    end
    chk("reach_wait_done", 128'(rsp_phase), 128'(2));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    reset   = 1'b0;
    force_d = 0;
    run_cmd(3, 1, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
